hist_mem_scheduler: RTL

- Sequences the time-correlation histogram RAM behind the bin-address generator.
- Queues bin-increment requests and performs a serialized, saturating read-modify-write for each one.
- Shares the RAM port with a host readout port and a full-memory clear sweep.
- Sits between the bin-address generator and the single-port histogram RAM; the readout side feeds the host/UART dump logic.

---
 rtl/hist_mem_scheduler.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/hist_mem_scheduler.sv
// Histogram RAM sequencer: queues bin increments and serialises saturating read-modify-writes,
// host readouts and full-memory clear sweeps onto one single-port RAM.
module hist_mem_scheduler #(
    parameter int ADDR_W     = 8,
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc_valid,
    input  logic [ADDR_W-1:0] inc_addr,
    output logic [15:0]       drop_cnt,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [CNT_W-1:0]  ram_wdata,
    input  logic [CNT_W-1:0]  ram_rdata,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_busy,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  rd_data,
    input  logic              clear_req,
    output logic              clear_busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int OW = PW + 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        INC_RD   = 3'd1,
        INC_WR   = 3'd2,
        HOST_RD  = 3'd3,
        HOST_RSP = 3'd4,
        CLEAR    = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] fifo_mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wptr_q, rptr_q;
    logic [OW-1:0]     occ_q, occ_d;
    logic [15:0]       drop_q, drop_d;
    logic              rd_busy_q, rd_busy_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [CNT_W-1:0]  rd_data_q;
    logic              clr_busy_q, clr_busy_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  wdata_q;
    logic              last_inc_q, last_inc_d;
    logic              push, pop, fifo_nonempty, clr_done;

    // Occupancy is tested before the same-cycle pop, so a full queue drops even while draining.
    assign push          = inc_valid && (occ_q < OW'(FIFO_DEPTH));
    assign pop           = (state_q == INC_RD);
    assign fifo_nonempty = (occ_q != '0);

    always_comb begin
        state_d    = state_q;
        ram_addr   = addr_q;
        ram_we     = 1'b0;
        ram_wdata  = wdata_q;
        last_inc_d = last_inc_q;
        clr_cnt_d  = clr_cnt_q;
        clr_done   = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_busy_q) begin
                    state_d = CLEAR;
                end else if (fifo_nonempty && rd_busy_q) begin
                    state_d    = last_inc_q ? HOST_RD : INC_RD;
                    last_inc_d = !last_inc_q;
                end else if (fifo_nonempty) begin
                    state_d    = INC_RD;
                    last_inc_d = 1'b1;
                end else if (rd_busy_q) begin
                    state_d    = HOST_RD;
                    last_inc_d = 1'b0;
                end
            end
            INC_RD: begin
                ram_addr = fifo_mem_q[rptr_q];
                state_d  = INC_WR;
            end
            INC_WR: begin
                ram_we    = 1'b1;
                ram_wdata = (&ram_rdata) ? ram_rdata : ram_rdata + 1'b1;
                state_d   = IDLE;
            end
            HOST_RD: begin
                ram_addr = rd_addr_q;
                state_d  = HOST_RSP;
            end
            HOST_RSP: state_d = IDLE;
            CLEAR: begin
                ram_addr  = clr_cnt_q;
                ram_we    = 1'b1;
                ram_wdata = '0;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (&clr_cnt_q) begin
                    clr_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        occ_d      = occ_q + OW'(push) - OW'(pop);
        drop_d     = drop_q;
        rd_busy_d  = rd_busy_q;
        rd_addr_d  = rd_addr_q;
        clr_busy_d = clr_busy_q;
        if (inc_valid && !push && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
        if (!rd_busy_q && rd_req) begin
            rd_busy_d = 1'b1;
            rd_addr_d = rd_addr;
        end else if (state_q == HOST_RSP) begin
            rd_busy_d = 1'b0;
        end
        if (!clr_busy_q && clear_req) begin
            clr_busy_d = 1'b1;
        end else if (clr_done) begin
            clr_busy_d = 1'b0;
        end
    end

    // Read data is passed straight through in the response cycle so it lines up with rd_valid.
    assign rd_valid   = (state_q == HOST_RSP);
    assign rd_data    = rd_valid ? ram_rdata : rd_data_q;
    assign rd_busy    = rd_busy_q;
    assign clear_busy = clr_busy_q;
    assign drop_cnt   = drop_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wptr_q     <= '0;
            rptr_q     <= '0;
            occ_q      <= '0;
            drop_q     <= '0;
            rd_busy_q  <= 1'b0;
            rd_addr_q  <= '0;
            rd_data_q  <= '0;
            clr_busy_q <= 1'b0;
            clr_cnt_q  <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            last_inc_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            drop_q     <= drop_d;
            rd_busy_q  <= rd_busy_d;
            rd_addr_q  <= rd_addr_d;
            rd_data_q  <= rd_data;
            clr_busy_q <= clr_busy_d;
            clr_cnt_q  <= clr_cnt_d;
            addr_q     <= ram_addr;
            wdata_q    <= ram_wdata;
            last_inc_q <= last_inc_d;
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wptr_q] <= inc_addr;
    end

endmodule
